// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared FSM state type, ALU function codes and default width for alu_arbiter.
package alu_arbiter_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam logic [3:0] F_AND  = 4'b0000;
  localparam logic [3:0] F_OR   = 4'b0001;
  localparam logic [3:0] F_ADD  = 4'b0010;
  localparam logic [3:0] F_SUB  = 4'b0110;
  localparam logic [3:0] F_SLT  = 4'b0111;
  localparam logic [3:0] F_SLTU = 4'b1111;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
endpackage

// File: rtl/alu.sv
// alu: combinational AND/OR/add/sub/signed and unsigned set-less-than; undefined codes yield 0.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       f,
  output logic [WIDTH-1:0] y,
  output logic             zero
);
  always_comb begin
    y = f == F_AND  ? a & b :
        f == F_OR   ? a | b :
        f == F_ADD  ? a + b :
        f == F_SUB  ? a - b :
        f == F_SLT  ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)} :
        f == F_SLTU ? {{(WIDTH-1){1'b0}}, a < b} : '0;
    zero = y == '0;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one alu through an IDLE/EXEC/RESP FSM.
// Define ALU_ARBITER_RR_EN for round-robin contention; default is fixed priority to requester 0.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][WIDTH-1:0] req_a,
  input  logic [1:0][WIDTH-1:0] req_b,
  input  logic [1:0][3:0]       req_f,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [WIDTH-1:0]      rsp_y,
  output logic                  rsp_zero,
  output logic                  busy
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d, alu_y;
  logic [3:0] f_q, f_d;
  logic owner_q, owner_d, last_grant_q, last_grant_d, zero_q, zero_d, alu_zero, gnt, hs;
`ifdef ALU_ARBITER_RR_EN
  assign gnt = &req_valid ? ~last_grant_q : req_valid[1];
`else
  assign gnt = ~req_valid[0];
`endif
  alu #(.WIDTH(WIDTH)) u_alu (.a(a_q), .b(b_q), .f(f_q), .y(alu_y), .zero(alu_zero));
  always_comb begin
    hs = reset && state_q == IDLE && req_valid[gnt];
    req_ready = hs ? 2'b01 << gnt : 2'b00;
    rsp_valid = state_q == RESP ? 2'b01 << owner_q : 2'b00;
    busy = state_q != IDLE;
    rsp_y = y_q;
    rsp_zero = zero_q;
    state_d = hs ? EXEC :
              state_q == EXEC ? RESP :
              state_q == RESP && rsp_ready[owner_q] ? IDLE : state_q;
    a_d = hs ? req_a[gnt] : a_q;
    b_d = hs ? req_b[gnt] : b_q;
    f_d = hs ? req_f[gnt] : f_q;
    owner_d = hs ? gnt : owner_q;
    last_grant_d = hs ? gnt : last_grant_q;
    y_d = state_q == EXEC ? alu_y : y_q;
    zero_d = state_q == EXEC ? alu_zero : zero_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      f_q <= '0;
      owner_q <= 1'b0;
      last_grant_q <= 1'b1;
      y_q <= '0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      f_q <= f_d;
      owner_q <= owner_d;
      last_grant_q <= last_grant_d;
      y_q <= y_d;
      zero_q <= zero_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a behavioural model.
module tb_alu_arbiter;
  logic clk = 0, reset = 0;
  logic [1:0] req_valid = 0, req_ready, rsp_valid, rsp_ready = 0;
  logic [1:0][31:0] req_a = 0, req_b = 0;
  logic [1:0][3:0] req_f = 0;
  logic [31:0] rsp_y;
  logic rsp_zero, busy;
  int vecs = 0, errs = 0, last_g = 1;
  logic [3:0] fcodes [6] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hF};

  alu_arbiter #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_f(req_f), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_zero(rsp_zero), .busy(busy));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_y(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      4'h6: return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      4'h7: return sa < sb ? 32'd1 : 32'd0;
      4'hF: return longint'(a) < longint'(b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int expected_grant(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
`ifdef ALU_ARBITER_RR_EN
    return last_g == 1 ? 0 : 1;
`else
    return 0;
`endif
  endfunction

  task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                        input int stall, input string nm);
    logic [31:0] ey;
    logic [1:0] oh;
    ey = ref_y(a, b, f);
    oh = 2'b01 << i;
    req_a[i] = a; req_b[i] = b; req_f[i] = f; req_valid = oh; rsp_ready = 0;
    #1;
    vecs++; if (req_ready !== oh) begin errs++; $display("FAIL %s_req_ready got=%b exp=%b", nm, req_ready, oh); end
    tick;
    req_valid = 0; last_g = i;
    vecs++; if (busy !== 1'b1 || rsp_valid !== 2'b00) begin errs++; $display("FAIL %s_exec busy=%b rsp_valid=%b exp busy=1 rsp_valid=00", nm, busy, rsp_valid); end
    tick;
    vecs++; if (rsp_valid !== oh || rsp_y !== ey || rsp_zero !== (ey == 0)) begin errs++;
      $display("FAIL %s_rsp got valid=%b y=%h zero=%b exp valid=%b y=%h zero=%b", nm, rsp_valid, rsp_y, rsp_zero, oh, ey, ey == 0); end
    for (int s = 0; s < stall; s++) begin
      req_valid = ~oh; rsp_ready = ~oh;
      #1;
      vecs++; if (req_ready !== 2'b00) begin errs++; $display("FAIL %s_resp_req_ready got=%b exp=00", nm, req_ready); end
      tick;
      vecs++; if (rsp_valid !== oh || rsp_y !== ey) begin errs++; $display("FAIL %s_hold got valid=%b y=%h exp valid=%b y=%h", nm, rsp_valid, rsp_y, oh, ey); end
    end
    req_valid = 0; rsp_ready = oh;
    tick;
    rsp_ready = 0;
    vecs++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin errs++; $display("FAIL %s_done busy=%b rsp_valid=%b exp busy=0 rsp_valid=00", nm, busy, rsp_valid); end
  endtask

  task automatic test_reset;
    reset = 0; req_valid = 0; rsp_ready = 0;
    tick;
    vecs++; if ({busy, req_ready, rsp_valid, rsp_zero} !== 6'b0 || rsp_y !== 32'd0) begin errs++;
      $display("FAIL reset busy=%b req_ready=%b rsp_valid=%b y=%h zero=%b exp all 0", busy, req_ready, rsp_valid, rsp_y, rsp_zero); end
    reset = 1; last_g = 1;
    tick;
    vecs++; if (req_ready !== 2'b00 || busy !== 1'b0) begin errs++; $display("FAIL idle_no_req req_ready=%b busy=%b exp 00 0", req_ready, busy); end
  endtask

  task automatic test_directed;
    run_op(0, 32'd5, 32'd7, 4'b0010, 0, "add0");
    run_op(1, 32'd5, 32'd5, 4'b0110, 0, "sub1");
    run_op(0, 32'hFFFF_FFFF, 32'd1, 4'b0111, 0, "slt");
    run_op(1, 32'hFFFF_FFFF, 32'd1, 4'b1111, 0, "sltu");
    run_op(0, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'b0000, 0, "and");
    run_op(1, 32'hF0F0_0000, 32'h0000_1234, 4'b0001, 4, "or_stall");
  endtask

  task automatic test_random;
    for (int n = 0; n < 30; n++)
      run_op(int'($urandom_range(1)), $urandom, n % 5 == 0 ? 32'd0 : $urandom,
             fcodes[$urandom_range(5)], int'($urandom_range(3)), "rand");
  endtask

  task automatic test_contention;
    logic [1:0] oh;
    logic [31:0] ey;
    int g;
    reset = 0; req_valid = 0; rsp_ready = 0;
    tick;
    reset = 1; last_g = 1;
    for (int k = 0; k < 2; k++) begin
      req_a[k] = $urandom; req_b[k] = $urandom; req_f[k] = fcodes[$urandom_range(5)];
    end
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int n = 0; n < 3; n++) begin
      g = expected_grant(req_valid);
      oh = 2'b01 << g;
      ey = ref_y(req_a[g], req_b[g], req_f[g]);
      #1;
      vecs++; if (req_ready !== oh) begin errs++; $display("FAIL contend%0d_grant got=%b exp=%b", n, req_ready, oh); end
      tick;
      last_g = g;
      tick;
      vecs++; if (rsp_valid !== oh || rsp_y !== ey) begin errs++; $display("FAIL contend%0d_rsp got valid=%b y=%h exp valid=%b y=%h", n, rsp_valid, rsp_y, oh, ey); end
      tick;
    end
    req_valid = 0; rsp_ready = 0;
    tick;
  endtask

  task automatic test_reset_exec;
    req_a[0] = 32'd9; req_b[0] = 32'd3; req_f[0] = 4'b0010; req_valid = 2'b01;
    tick;
    req_valid = 0;
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL rexec_busy got=%b exp=1", busy); end
    reset = 0;
    tick;
    reset = 1; last_g = 1;
    vecs++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || rsp_y !== 32'd0 || rsp_zero !== 1'b0) begin errs++;
      $display("FAIL rexec_abort busy=%b rsp_valid=%b y=%h zero=%b exp 0 00 0 0", busy, rsp_valid, rsp_y, rsp_zero); end
    rsp_ready = 2'b11;
    for (int n = 0; n < 4; n++) begin
      tick;
      vecs++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin errs++; $display("FAIL rexec_stale%0d rsp_valid=%b busy=%b exp 00 0", n, rsp_valid, busy); end
    end
    rsp_ready = 0;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_contention;
    test_reset_exec;
    test_random;
    test_contention;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
